// File: rtl/cordic_alu_pkg.sv
// Shared opcode encoding and IEEE-754 binary32 constants for the CORDIC ALU.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00000,
        OP_SUB  = 5'b00001,
        OP_MUL  = 5'b00010,
        OP_AND  = 5'b00011,
        OP_OR   = 5'b00100,
        OP_XOR  = 5'b00101,
        OP_SRL  = 5'b00110,
        OP_SLL  = 5'b00111,
        OP_FADD = 5'b10000,
        OP_FSUB = 5'b10001
    } alu_op_e;

    localparam int          FP_BIAS    = 127;
    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

endpackage

// File: rtl/cordic_alu_if.sv
// Operand/result bundle between the datapath driver and the ALU.
interface cordic_alu_if;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  ALUControl;
    logic [63:0] result;
    logic        V;
    logic        C;
    logic        Z;
    logic        N;

    modport master (output a, b, ALUControl, input result, V, C, Z, N);
    modport slave  (input a, b, ALUControl, output result, V, C, Z, N);
endinterface

// File: rtl/cordic_alu_fp_addsub.sv
// Combinational binary32 add/subtract: flush-to-zero on subnormals, RNE rounding.
module fp_addsub
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] res,
    output logic        ovf
);

    logic              sa, sb, sx, sy;
    logic [7:0]        ea, eb, ex, ey, d;
    logic [22:0]       fa, fb, fx, fy;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [26:0]       mx_ext, my_ext, my_sh;
    logic              sticky;
    logic [27:0]       v;
    logic [26:0]       n;
    logic [4:0]        lz;
    logic signed [9:0] e;
    logic              rnd_up;
    logic [24:0]       mant;
    logic [22:0]       frac;

    // Decode, align, add/sub, normalize, round, then let special cases override.
    always_comb begin
        sa     = a[31];
        sb     = b[31] ^ sub;
        ea     = a[30:23];
        eb     = b[30:23];
        fa     = a[22:0];
        fb     = b[22:0];
        a_nan  = (ea == FP_EXP_MAX) && (fa != 23'd0);
        b_nan  = (eb == FP_EXP_MAX) && (fb != 23'd0);
        a_inf  = (ea == FP_EXP_MAX) && (fa == 23'd0);
        b_inf  = (eb == FP_EXP_MAX) && (fb == 23'd0);
        // Subnormals carry no hidden bit here; they count as zero.
        a_zero = (ea == 8'd0);
        b_zero = (eb == 8'd0);

        // Larger magnitude goes to x so the subtraction never goes negative.
        if (a[30:0] >= b[30:0]) begin
            sx = sa; ex = ea; fx = fa;
            sy = sb; ey = eb; fy = fb;
        end else begin
            sx = sb; ex = eb; fx = fb;
            sy = sa; ey = ea; fy = fa;
        end

        // Three extra low bits hold guard, round and sticky.
        mx_ext = {1'b1, fx, 3'b000};
        my_ext = {1'b1, fy, 3'b000};
        d      = ex - ey;
        if (d > 8'd26) begin
            my_sh  = 27'd0;
            sticky = 1'b1;
        end else begin
            my_sh  = my_ext >> d;
            sticky = |(my_ext & ~(27'h7FF_FFFF << d));
        end
        my_sh[0] = my_sh[0] | sticky;

        if (sx == sy) v = {1'b0, mx_ext} + {1'b0, my_sh};
        else          v = {1'b0, mx_ext} - {1'b0, my_sh};

        lz = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) lz = 5'(26 - i);
        end

        if (v[27]) begin
            n = {v[27:2], v[1] | v[0]};
            e = $signed({2'b00, ex}) + 10'sd1;
        end else begin
            n = v[26:0] << lz;
            e = $signed({2'b00, ex}) - $signed({5'b00000, lz});
        end

        rnd_up = n[2] & (n[1] | n[0] | n[3]);
        mant   = {1'b0, n[26:3]} + {24'd0, rnd_up};
        if (mant[24]) begin
            e    = e + 10'sd1;
            frac = mant[23:1];
        end else begin
            frac = mant[22:0];
        end

        ovf = 1'b0;
        if (v == 28'd0) begin
            res = 32'd0;
        end else if (e >= 10'sd255) begin
            res = {sx, FP_EXP_MAX, 23'd0};
            ovf = 1'b1;
        end else if (e <= 10'sd0) begin
            res = {sx, 31'd0};
        end else begin
            res = {sx, e[7:0], frac};
        end

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            res = FP_QNAN;
            ovf = 1'b0;
        end else if (a_inf) begin
            res = {sa, FP_EXP_MAX, 23'd0};
            ovf = 1'b0;
        end else if (b_inf) begin
            res = {sb, FP_EXP_MAX, 23'd0};
            ovf = 1'b0;
        end else if (a_zero && b_zero) begin
            res = {sa & sb, 31'd0};
            ovf = 1'b0;
        end else if (a_zero) begin
            res = {sb, b[30:0]};
            ovf = 1'b0;
        end else if (b_zero) begin
            res = a;
            ovf = 1'b0;
        end
    end

endmodule

// File: rtl/cordic_alu.sv
// Single-cycle registered integer / binary32 ALU with V/C/Z/N flags.
module cordic_alu
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    cordic_alu_if.slave  bus
);

    logic [63:0] result_d, result_q;
    logic        v_d, v_q, c_d, c_q, z_d, z_q, n_d, n_q;
    logic [32:0] sum33, diff33;
    logic [63:0] prod;
    logic [31:0] lres;
    logic [31:0] fp_res;
    logic        fp_ovf;

    fp_addsub u_fp (
        .a   (bus.a),
        .b   (bus.b),
        .sub (bus.ALUControl == OP_FSUB),
        .res (fp_res),
        .ovf (fp_ovf)
    );

    // Integer datapath, result mux and flag generation.
    always_comb begin
        result_d = 64'd0;
        v_d      = 1'b0;
        c_d      = 1'b0;
        z_d      = 1'b0;
        n_d      = 1'b0;
        sum33    = {1'b0, bus.a} + {1'b0, bus.b};
        diff33   = {1'b0, bus.a} - {1'b0, bus.b};
        prod     = {32'd0, bus.a} * {32'd0, bus.b};
        lres     = 32'd0;
        case (bus.ALUControl)
            OP_ADD: begin
                result_d = {31'd0, sum33};
                c_d      = sum33[32];
                v_d      = (bus.a[31] == bus.b[31]) && (sum33[31] != bus.a[31]);
                z_d      = (sum33[31:0] == 32'd0);
                n_d      = sum33[31];
            end
            OP_SUB: begin
                result_d = {31'd0, diff33};
                c_d      = diff33[32];
                v_d      = (bus.a[31] != bus.b[31]) && (diff33[31] != bus.a[31]);
                z_d      = (diff33[31:0] == 32'd0);
                n_d      = diff33[31];
            end
            OP_MUL: begin
                result_d = prod;
                z_d      = (prod == 64'd0);
                n_d      = prod[63];
            end
            OP_AND, OP_OR, OP_XOR, OP_SRL, OP_SLL: begin
                case (bus.ALUControl)
                    OP_AND:  lres = bus.a & bus.b;
                    OP_OR:   lres = bus.a | bus.b;
                    OP_XOR:  lres = bus.a ^ bus.b;
                    OP_SRL:  lres = bus.a >> bus.b[4:0];
                    default: lres = bus.a << bus.b[4:0];
                endcase
                result_d = {32'd0, lres};
                z_d      = (lres == 32'd0);
                n_d      = lres[31];
            end
            OP_FADD, OP_FSUB: begin
                result_d = {32'd0, fp_res};
                v_d      = fp_ovf;
                z_d      = (fp_res[30:0] == 31'd0);
                n_d      = fp_res[31];
            end
            default: ;
        endcase
    end

    // Output registers; reset discards whatever was being computed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= 64'd0;
            v_q      <= 1'b0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
        end else begin
            result_q <= result_d;
            v_q      <= v_d;
            c_q      <= c_d;
            z_q      <= z_d;
            n_q      <= n_d;
        end
    end

    assign bus.result = result_q;
    assign bus.V      = v_q;
    assign bus.C      = c_q;
    assign bus.Z      = z_q;
    assign bus.N      = n_q;

endmodule

// File: tb/tb_cordic_alu.sv
// Scoreboard bench for cordic_alu: each issued op expects its result one edge later.
module tb_cordic_alu;
    import alu_pkg::*;

    typedef struct {
        logic [63:0] res;
        logic [3:0]  vczn;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    cordic_alu_if bus ();

    cordic_alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Items are pushed 2 time units after an edge, so the one at the head
    // when this runs was driven exactly one edge earlier.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (bus.result !== e.res) begin
                errors++;
                $display("FAIL %s result got %h want %h", e.name, bus.result, e.res);
            end
            checks++;
            if ({bus.V, bus.C, bus.Z, bus.N} !== e.vczn) begin
                errors++;
                $display("FAIL %s flags VCZN got %b want %b", e.name, {bus.V, bus.C, bus.Z, bus.N}, e.vczn);
            end
        end
    end

    task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic [4:0] op,
                         input logic [63:0] er, input logic [3:0] ef, input string nm);
        exp_t e;
        @(posedge clk);
        #2;
        bus.a          = ta;
        bus.b          = tb;
        bus.ALUControl = op;
        e.res  = er;
        e.vczn = ef;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n          = 1'b0;
        bus.a          = 32'hFFFF_FFFF;
        bus.b          = 32'h1;
        bus.ALUControl = OP_ADD;
        repeat (2) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.result !== 64'd0) begin
                errors++;
                $display("FAIL reset result got %h want %h", bus.result, 64'd0);
            end
            checks++;
            if ({bus.V, bus.C, bus.Z, bus.N} !== 4'b0000) begin
                errors++;
                $display("FAIL reset flags got %b want 0000", {bus.V, bus.C, bus.Z, bus.N});
            end
        end
        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        e.res  = 64'h1_0000_0000;
        e.vczn = 4'b0110;
        e.name = "reset_release_add";
        sb_q.push_back(e);
    endtask

    task automatic test_add_sub();
        issue(32'h7FFF_FFFF, 32'h1, OP_ADD, 64'h8000_0000, 4'b1001, "add_ovf");
        issue(32'h1234_5678, 32'h1111_1111, OP_ADD, 64'h2345_6789, 4'b0000, "add_plain");
        issue(32'h1, 32'h2, OP_SUB, 64'h1_FFFF_FFFF, 4'b0101, "sub_borrow");
        issue(32'h5, 32'h5, OP_SUB, 64'h0, 4'b0010, "sub_zero");
        issue(32'h8000_0000, 32'h1, OP_SUB, 64'h7FFF_FFFF, 4'b1000, "sub_ovf");
    endtask

    task automatic test_mul();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MUL, 64'hFFFF_FFFE_0000_0001, 4'b0001, "mul_max");
        issue(32'h0, 32'hDEAD_BEEF, OP_MUL, 64'h0, 4'b0010, "mul_zero");
        issue(32'h0001_0000, 32'h0001_0000, OP_MUL, 64'h1_0000_0000, 4'b0000, "mul_hi");
    endtask

    task automatic test_logic_shift();
        logic [31:0] ra, rb, r;
        logic [4:0]  op;
        for (int i = 0; i < 500; i++) begin
            ra = $urandom;
            rb = $urandom;
            case (i / 100)
                0:       begin op = OP_AND; r = ra & rb; end
                1:       begin op = OP_OR;  r = ra | rb; end
                2:       begin op = OP_XOR; r = ra ^ rb; end
                3:       begin op = OP_SRL; r = ra >> rb[4:0]; end
                default: begin op = OP_SLL; r = ra << rb[4:0]; end
            endcase
            issue(ra, rb, op, {32'd0, r}, {2'b00, r == 32'd0, r[31]}, "logic_shift_rand");
        end
        issue(32'h8000_0000, 32'h0000_003F, OP_SRL, 64'h1, 4'b0000, "srl_b_masked");
        issue(32'h0000_0001, 32'hFFFF_FFFF, OP_SLL, 64'h8000_0000, 4'b0001, "sll_31");
        issue(32'hF0F0_F0F0, 32'h0F0F_0F0F, OP_AND, 64'h0, 4'b0010, "and_zero");
    endtask

    task automatic test_fp();
        issue(32'h3F80_0000, 32'h4000_0000, OP_FADD, 64'h4040_0000, 4'b0000, "fadd_1_2");
        issue(32'h3F80_0000, 32'h3F80_0000, OP_FSUB, 64'h0, 4'b0010, "fsub_cancel");
        issue(32'h7F7F_FFFF, 32'h7F7F_FFFF, OP_FADD, 64'h7F80_0000, 4'b1000, "fadd_ovf");
        issue(32'h7FC0_0000, 32'h3F80_0000, OP_FADD, 64'h7FC0_0000, 4'b0000, "fadd_nan");
        issue(32'h7F80_0000, 32'h7F80_0000, OP_FSUB, 64'h7FC0_0000, 4'b0000, "fsub_inf_inf");
        issue(32'h3F80_0000, 32'hFF80_0000, OP_FADD, 64'hFF80_0000, 4'b0001, "fadd_neg_inf");
        issue(32'hBFC0_0000, 32'h3F80_0000, OP_FADD, 64'hBF00_0000, 4'b0001, "fadd_neg_half");
        issue(32'h4000_0000, 32'h3F80_0000, OP_FSUB, 64'h3F80_0000, 4'b0000, "fsub_2_1");
        issue(32'h0000_0001, 32'h3F80_0000, OP_FADD, 64'h3F80_0000, 4'b0000, "fadd_subnormal");
        issue(32'h3F80_0000, 32'h3380_0000, OP_FADD, 64'h3F80_0000, 4'b0000, "fadd_tie_even");
        issue(32'h3F80_0001, 32'h3380_0000, OP_FADD, 64'h3F80_0002, 4'b0000, "fadd_tie_up");
        issue(32'h0080_0000, 32'h0080_0001, OP_FSUB, 64'h8000_0000, 4'b0011, "fsub_flush");
    endtask

    task automatic test_back_to_back();
        issue(32'h2, 32'h3, OP_ADD, 64'h5, 4'b0000, "b2b_add");
        issue(32'h3, 32'h4, OP_MUL, 64'hC, 4'b0000, "b2b_mul");
        issue(32'h4040_0000, 32'h3F80_0000, OP_FSUB, 64'h4000_0000, 4'b0000, "b2b_fsub");
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b11111, 64'h0, 4'b0000, "b2b_illegal");
        issue(32'h1, 32'h1, OP_ADD, 64'h2, 4'b0000, "b2b_after");
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_logic_shift();
        test_fp();
        test_back_to_back();
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
